// File: rtl/axi_wr_pkg.sv
// Shared AXI write-channel constants and W-channel FSM encoding for axi_burst_wr_ctrl.
package axi_wr_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_e;

    // AxSIZE encoding for a data bus of the given width in bytes.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/wr_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head entry; pushes when full and pops
// when empty are dropped.
module wr_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wr_ptr_d  = wr_ptr_q + {{PW{1'b0}}, do_push};
        rd_ptr_d  = rd_ptr_q + {{PW{1'b0}}, do_pop};
        head_data = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/axi_burst_wr_ctrl.sv
// AXI4 burst write master: queued commands, decoupled AW/W issue, WLAST from a beat counter.
// Optional B-channel tracking (outstanding limit, wr_err) enabled by AXI_WR_RESP_CHECK_EN.
module axi_burst_wr_ctrl
    import axi_wr_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int ID_WIDTH        = 4,
    parameter int LEN_WIDTH       = 8,
    parameter int CMD_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [CTRL_ADDR_WIDTH-1:0] wr_addr,
    input  logic [ID_WIDTH-1:0]        wr_id,
    input  logic [LEN_WIDTH-1:0]       wr_len,
    output logic                       wr_cmd_ready,
    input  logic                       wr_data_en,
    input  logic [MEM_DQ_WIDTH*8-1:0]  wr_data,
    output logic                       wr_ready,
    output logic                       wr_last,
    output logic                       wr_cmd_done,
    output logic                       wr_err,
    output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [ID_WIDTH-1:0]        axi_awid,
    output logic [LEN_WIDTH-1:0]       axi_awlen,
    output logic [2:0]                 axi_awsize,
    output logic [1:0]                 axi_awburst,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
    output logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
    output logic                       axi_wlast,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,
    input  logic [ID_WIDTH-1:0]        axi_bid,
    input  logic [1:0]                 axi_bresp,
    input  logic                       axi_bvalid,
    output logic                       axi_bready,
    output logic [3:0]                 pend_cnt
);
    localparam int         AWQ_W   = CTRL_ADDR_WIDTH + ID_WIDTH + LEN_WIDTH;
    localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

    logic                       aw_full, aw_empty, aw_pop;
    logic [AWQ_W-1:0]           aw_head;
    logic                       w_full, w_empty, w_pop;
    logic [LEN_WIDTH-1:0]       w_head;
    logic                       cmd_push;

    logic                       awvalid_q, awvalid_d;
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ID_WIDTH-1:0]        awid_q, awid_d;
    logic [LEN_WIDTH-1:0]       awlen_q, awlen_d;
    logic                       aw_hs, aw_slot_ok;

    w_state_e                   w_state_q, w_state_d;
    logic [LEN_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]       beat_len_q, beat_len_d;
    logic                       w_valid, w_last, w_hs;

    logic                       bready_q, bready_d;
    logic                       done_q, done_d;
    logic                       resp_unused;

    assign wr_cmd_ready = !aw_full && !w_full;
    assign cmd_push     = wr_en && wr_cmd_ready;

    wr_cmd_fifo #(.WIDTH(AWQ_W), .DEPTH(CMD_DEPTH)) u_aw_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({wr_addr, wr_id, wr_len}),
        .pop       (aw_pop),
        .head_data (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    wr_cmd_fifo #(.WIDTH(LEN_WIDTH), .DEPTH(CMD_DEPTH)) u_w_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data (wr_len),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // AW register refills in the handshake cycle so bursts can go back to back.
    always_comb begin
        aw_hs     = awvalid_q && axi_awready;
        aw_pop    = !aw_empty && (!awvalid_q || axi_awready) && aw_slot_ok;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awid_d    = awid_q;
        awlen_d   = awlen_q;
        if (aw_pop) begin
            awvalid_d                    = 1'b1;
            {awaddr_d, awid_d, awlen_d}  = aw_head;
        end else if (aw_hs) begin
            awvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awid_q    <= '0;
            awlen_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
        end
    end

    // W_IDLE | no burst loaded; W_BURST | streaming beats of the loaded burst
    always_comb begin
        w_state_d  = w_state_q;
        beat_cnt_d = beat_cnt_q;
        beat_len_d = beat_len_q;
        w_pop      = 1'b0;
        w_valid    = (w_state_q == W_BURST) && wr_data_en;
        w_last     = (w_state_q == W_BURST) && (beat_cnt_q == beat_len_q);
        w_hs       = w_valid && axi_wready;
        case (w_state_q)
            W_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    beat_len_d = w_head;
                    beat_cnt_d = '0;
                    w_state_d  = W_BURST;
                end
            end
            W_BURST: begin
                if (w_hs) begin
                    if (w_last) begin
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            beat_len_d = w_head;
                            beat_cnt_d = '0;
                        end else begin
                            w_state_d = W_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            beat_cnt_q <= '0;
            beat_len_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            beat_cnt_q <= beat_cnt_d;
            beat_len_q <= beat_len_d;
        end
    end

    assign bready_d = 1'b1;

`ifdef AXI_WR_RESP_CHECK_EN
    logic       b_hs;
    logic [3:0] pend_cnt_q, pend_cnt_d;
    logic       err_q, err_d;

    // The slot check counts the burst currently presented on AW as already taken.
    assign aw_slot_ok = ({1'b0, pend_cnt_q} + {4'd0, awvalid_q}) < MAX_OUT;

    always_comb begin
        b_hs       = axi_bvalid && bready_q;
        pend_cnt_d = pend_cnt_q;
        case ({aw_hs, b_hs})
            2'b10:   pend_cnt_d = pend_cnt_q + 4'd1;
            2'b01:   pend_cnt_d = (pend_cnt_q == 4'd0) ? 4'd0 : pend_cnt_q - 4'd1;
            default: pend_cnt_d = pend_cnt_q;
        endcase
        err_d  = err_q || (b_hs && ((axi_bresp != RESP_OKAY) || (pend_cnt_q == 4'd0)));
        done_d = b_hs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pend_cnt    = pend_cnt_q;
    assign wr_err      = err_q;
    assign resp_unused = ^{axi_bid, MAX_OUT};
`else
    assign aw_slot_ok  = 1'b1;
    assign done_d      = w_hs && w_last;
    assign pend_cnt    = 4'd0;
    assign wr_err      = 1'b0;
    assign resp_unused = ^{axi_bid, axi_bresp, axi_bvalid, MAX_OUT};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bready_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            bready_q <= bready_d;
            done_q   <= done_d;
        end
    end

    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awid    = awid_q;
    assign axi_awlen   = awlen_q;
    assign axi_awsize  = axi_size(MEM_DQ_WIDTH);
    assign axi_awburst = BURST_INCR;
    assign axi_wdata   = wr_data;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = w_valid;
    assign axi_wlast   = w_last;
    assign axi_bready  = bready_q;
    assign wr_ready    = w_hs;
    assign wr_last     = w_hs && w_last;
    assign wr_cmd_done = done_q;

endmodule

// File: tb/tb_axi_burst_wr_ctrl.sv
// Directed bench for axi_burst_wr_ctrl; expectations follow AXI_WR_RESP_CHECK_EN when defined.
module tb_axi_burst_wr_ctrl;
    localparam int AW = 28, DQ = 16, IDW = 4, LW = 8, DEPTH = 4, MAXO = 2;
`ifdef AXI_WR_RESP_CHECK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    logic              clk, rst_n;
    logic              wr_en, wr_cmd_ready, wr_data_en, wr_ready, wr_last, wr_cmd_done, wr_err;
    logic [AW-1:0]     wr_addr, axi_awaddr;
    logic [IDW-1:0]    wr_id, axi_awid, axi_bid;
    logic [LW-1:0]     wr_len, axi_awlen;
    logic [DQ*8-1:0]   wr_data, axi_wdata;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst, axi_bresp;
    logic              axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic              axi_bvalid, axi_bready;
    logic [DQ-1:0]     axi_wstrb;
    logic [3:0]        pend_cnt;

    axi_burst_wr_ctrl #(
        .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .ID_WIDTH(IDW),
        .LEN_WIDTH(LW), .CMD_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_id(wr_id),
        .wr_len(wr_len), .wr_cmd_ready(wr_cmd_ready), .wr_data_en(wr_data_en),
        .wr_data(wr_data), .wr_ready(wr_ready), .wr_last(wr_last),
        .wr_cmd_done(wr_cmd_done), .wr_err(wr_err), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor samples 1 ns before each rising edge.
    typedef struct { logic [AW-1:0] addr; logic [IDW-1:0] id; logic [LW-1:0] len; } aw_rec_t;
    aw_rec_t aw_q[$];
    int      wburst_q[$];
    int      beat_cyc[$];
    int      cyc = 0, cur_beats = 0, done_cnt = 0, last_cnt = 0;

    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (!rst_n) begin
            cur_beats = 0;
        end else begin
            if (axi_awvalid && axi_awready) aw_q.push_back(aw_rec_t'{axi_awaddr, axi_awid, axi_awlen});
            if (axi_wvalid && axi_wready) begin
                beat_cyc.push_back(cyc);
                cur_beats++;
                if (axi_wlast) begin
                    wburst_q.push_back(cur_beats);
                    cur_beats = 0;
                end
            end
            if (wr_last) last_cnt++;
            if (wr_cmd_done) done_cnt++;
        end
    end

    logic       b_force = 1'b0;
    logic [1:0] b_resp_f = 2'b00;
    bit         auto_b = 1'b0;

    task automatic nxt();
        @(negedge clk);
        axi_bvalid = b_force | (auto_b & (pend_cnt != 4'd0));
        axi_bresp  = b_force ? b_resp_f : 2'b00;
        b_force    = 1'b0;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [LW-1:0] len);
        wr_en = 1'b1; wr_addr = a; wr_id = id; wr_len = len;
        nxt();
        wr_en = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input string name);
        int n = 0;
        while (wburst_q.size() < target && n < 2000) begin nxt(); n++; end
        check(name, wburst_q.size(), target);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 2000) begin nxt(); n++; end
        check(name, done_cnt, target);
    endtask

    typedef struct { logic [AW-1:0] addr; logic [IDW-1:0] id; logic [LW-1:0] len; int exp_beats; } vec_t;
    vec_t vecs[4];

    initial begin
        int bw, ba, bd, bl, bb, n;
        vecs[0] = '{28'h0001000, 4'h1, 8'd0,   1};
        vecs[1] = '{28'h0002000, 4'h2, 8'd7,   8};
        vecs[2] = '{28'h0003000, 4'h3, 8'd255, 256};
        vecs[3] = '{28'h0004000, 4'h4, 8'd1,   2};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_id = '0; wr_len = '0;
        wr_data_en = 1'b1; wr_data = {$urandom, $urandom, $urandom, $urandom};
        axi_awready = 1'b0; axi_wready = 1'b1; axi_bid = '0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
        run(3);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_awaddr", axi_awaddr, 0);
        check("rst_awlen", axi_awlen, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_wlast", axi_wlast, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_done", wr_cmd_done, 0);
        check("rst_err", wr_err, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_cmd_ready", wr_cmd_ready, 1);
        check("awsize", axi_awsize, 4);
        check("awburst", axi_awburst, 1);
        check("wstrb", axi_wstrb, 16'hFFFF);
        rst_n = 1'b1;
        nxt();
        check("bready_after_rst", axi_bready, 1);

        // Single burst len=3 with AW stall, W stall, then B.
        bw = wburst_q.size(); bd = done_cnt; bl = last_cnt; ba = aw_q.size();
        push(28'h0000100, 4'h3, 8'd3);
        check("t1_awvalid_cyc1", axi_awvalid, 0);
        check("t1_wvalid_cyc1", axi_wvalid, 0);
        nxt();
        check("t1_awvalid_cyc2", axi_awvalid, 1);
        check("t1_awaddr", axi_awaddr, 28'h100);
        check("t1_awlen", axi_awlen, 3);
        check("t1_awid", axi_awid, 3);
        check("t1_wvalid_cyc2", axi_wvalid, 1);
        check("t1_wlast_beat1", axi_wlast, 0);
        check("t1_wdata", axi_wdata == wr_data, 1);
        axi_wready = 1'b0;
        #1;
        check("t1_wr_ready_stall", wr_ready, 0);
        nxt();
        check("t1_awvalid_hold", axi_awvalid, 1);
        check("t1_awaddr_hold", axi_awaddr, 28'h100);
        axi_wready = 1'b1; axi_awready = 1'b1;
        #1;
        check("t1_wr_ready", wr_ready, 1);
        nxt();
        axi_awready = 1'b0;
        check("t1_awvalid_drop", axi_awvalid, 0);
        check("t1_pend_after_aw", pend_cnt, RESP_CHK ? 1 : 0);
        run(2);
        check("t1_wlast_beat4", axi_wlast, 1);
        check("t1_wr_last_beat4", wr_last, 1);
        nxt();
        check("t1_wvalid_idle", axi_wvalid, 0);
        wait_bursts(bw + 1, "t1_burst_timeout");
        check("t1_beats", wburst_q[bw], 4);
        nxt();
        check("t1_done_before_b", done_cnt - bd, RESP_CHK ? 0 : 1);
        b_force = 1'b1; b_resp_f = 2'b00;
        run(3);
        check("t1_done_after_b", done_cnt - bd, 1);
        check("t1_wr_last_cnt", last_cnt - bl, 1);
        check("t1_aw_cnt", aw_q.size() - ba, 1);
        check("t1_pend_final", pend_cnt, 0);
        check("t1_err", wr_err, 0);

        // Table: back-to-back bursts, W must stream without a bubble.
        axi_awready = 1'b1; auto_b = 1'b1;
        bw = wburst_q.size(); ba = aw_q.size(); bd = done_cnt; bl = last_cnt; bb = beat_cyc.size();
        for (int i = 0; i < 4; i++) push(vecs[i].addr, vecs[i].id, vecs[i].len);
        wait_bursts(bw + 4, "t2_burst_timeout");
        wait_done(bd + 4, "t2_done_timeout");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_beats_%0d", i), wburst_q[bw + i], vecs[i].exp_beats);
            check($sformatf("t2_awaddr_%0d", i), aw_q[ba + i].addr, vecs[i].addr);
            check($sformatf("t2_awlen_%0d", i), aw_q[ba + i].len, vecs[i].len);
            check($sformatf("t2_awid_%0d", i), aw_q[ba + i].id, vecs[i].id);
        end
        check("t2_beat_total", beat_cyc.size() - bb, 267);
        check("t2_no_bubble", beat_cyc[beat_cyc.size() - 1] - beat_cyc[bb] + 1, 267);
        check("t2_wr_last_cnt", last_cnt - bl, 4);

        // Full queue: one burst parked in AW register and W FSM, then fill the queues.
        axi_awready = 1'b0; wr_data_en = 1'b0;
        run(3);
        bw = wburst_q.size(); ba = aw_q.size(); bd = done_cnt;
        push(28'h0004000, 4'h0, 8'd0);
        run(3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_ready_%0d", k), wr_cmd_ready, 1);
            push(28'h0005000 + 28'(k * 256), 4'(k), 8'd1);
        end
        check("t3_ready_full", wr_cmd_ready, 0);
        push(28'h00BEEF0, 4'hF, 8'd5);
        check("t3_ready_still_full", wr_cmd_ready, 0);
        axi_awready = 1'b1; wr_data_en = 1'b1;
        wait_bursts(bw + 5, "t3_burst_timeout");
        wait_done(bd + 5, "t3_done_timeout");
        run(20);
        check("t3_burst_cnt", wburst_q.size() - bw, 5);
        check("t3_aw_cnt", aw_q.size() - ba, 5);
        check("t3_last_addr", aw_q[aw_q.size() - 1].addr, 28'h0005300);
        check("t3_last_beats", wburst_q[wburst_q.size() - 1], 2);

        // Outstanding limit (MAX_OUTSTANDING=2) with B withheld.
        auto_b = 1'b0;
        run(5);
        check("t4_pend_start", pend_cnt, 0);
        ba = aw_q.size(); bd = done_cnt;
        push(28'h0006000, 4'h1, 8'd0);
        push(28'h0006100, 4'h2, 8'd0);
        push(28'h0006200, 4'h3, 8'd0);
        run(10);
        check("t4_aw_blocked", aw_q.size() - ba, RESP_CHK ? 2 : 3);
        check("t4_pend_full", pend_cnt, RESP_CHK ? 2 : 0);
        check("t4_awvalid_blocked", axi_awvalid, 0);
        b_force = 1'b1; b_resp_f = 2'b00;
        nxt();
        nxt();
        check("t4_awvalid_b_cycle", axi_awvalid, 0);
        check("t4_pend_after_b", pend_cnt, RESP_CHK ? 1 : 0);
        nxt();
        check("t4_awvalid_freed", axi_awvalid, RESP_CHK);
        auto_b = 1'b1;
        run(10);
        check("t4_aw_total", aw_q.size() - ba, 3);
        check("t4_pend_drained", pend_cnt, 0);
        wait_done(bd + 3, "t4_done_timeout");

        // Error response is sticky.
        auto_b = 1'b0;
        check("t5_err_before", wr_err, 0);
        b_force = 1'b1; b_resp_f = 2'b10;
        run(2);
        check("t5_err_set", wr_err, RESP_CHK);
        check("t5_pend_no_underflow", pend_cnt, 0);
        run(5);
        check("t5_err_sticky", wr_err, RESP_CHK);

        // Async reset at beat 2 of a len=7 burst, then a clean burst.
        axi_awready = 1'b0; wr_data_en = 1'b1;
        push(28'h0002000, 4'h5, 8'd7);
        n = 0;
        while (cur_beats < 2 && n < 50) begin nxt(); n++; end
        check("t6_beat2_reached", cur_beats >= 2, 1);
        check("t6_awvalid_pre", axi_awvalid, 1);
        check("t6_wvalid_pre", axi_wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_awvalid_rst", axi_awvalid, 0);
        check("t6_wvalid_rst", axi_wvalid, 0);
        check("t6_wlast_rst", axi_wlast, 0);
        check("t6_pend_rst", pend_cnt, 0);
        check("t6_err_rst", wr_err, 0);
        check("t6_ready_rst", wr_cmd_ready, 1);
        run(2);
        rst_n = 1'b1;
        nxt();
        check("t6_bready", axi_bready, 1);
        axi_awready = 1'b1; auto_b = 1'b1;
        bw = wburst_q.size(); ba = aw_q.size(); bd = done_cnt;
        push(28'h0003000, 4'h6, 8'd2);
        wait_bursts(bw + 1, "t6_burst_timeout");
        wait_done(bd + 1, "t6_done_timeout");
        run(5);
        check("t6_beats", wburst_q[bw], 3);
        check("t6_awaddr", aw_q[ba].addr, 28'h0003000);
        check("t6_awlen", aw_q[ba].len, 2);
        check("t6_pend_final", pend_cnt, 0);
        check("t6_err_final", wr_err, 0);

        // B with nothing outstanding is an error when response checking is on.
        auto_b = 1'b0;
        b_force = 1'b1; b_resp_f = 2'b00;
        run(3);
        check("t7_err_spurious_b", wr_err, RESP_CHK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
